video_dither_multi: RTL and testbench
=====================================

// Module: video_dither_multi
//
// PURPOSE
//  Parametrised successor to the 4-bit VGA dither stage. It sits between the ZPU video
//  generator (8-bit RGB) and the DAC pins, and reduces INBITS-per-channel colour to
//  OUTBITS per channel. Modes are selectable at run time: plain truncation, a 2x2
//  ordered Bayer pattern rotated each frame, or temporal LFSR noise. Syncs and the
//  blank window are delayed to match the data path.
//
// PARAMETERS
//  INBITS   8   input bits per colour channel
//  OUTBITS  4   output bits per colour channel; INBITS-OUTBITS must be >= 2
//  SEED     16'hACE1   LFSR reset value; must be non-zero
//
// PORTS
//  clk       in   1        pixel/system clock; single clock domain
//  reset_n   in   1        asynchronous active-low reset
//  mode      in   2        0=truncate, 1=ordered 2x2, 2=LFSR noise, 3=reserved (acts as 0)
//  hsync     in   1        horizontal sync, active high
//  vsync     in   1        vertical sync, active high
//  vid_ena   in   1        active-pixel window
//  iRed      in   INBITS   red in
//  iGreen    in   INBITS   green in
//  iBlue     in   INBITS   blue in
//  oHsync    out  1        hsync delayed by 2 cycles
//  oVsync    out  1        vsync delayed by 2 cycles
//  oVid_ena  out  1        vid_ena delayed by 2 cycles
//  oRed      out  OUTBITS  dithered red
//  oGreen    out  OUTBITS  dithered green
//  oBlue     out  OUTBITS  dithered blue
//
// BEHAVIOUR
//  - Reset: all outputs 0, pipeline regs 0, x/y/frame counters 0, LFSR=SEED. Reset
//    mid-line takes effect immediately. After release, the first valid pixel is out 2 clocks after it enters.
//  - Latency: exactly 2 clk for data, syncs and vid_ena. Stage 1 registers the inputs and
//    the threshold. Stage 2 does the add, saturate and truncate.
//  - D = INBITS-OUTBITS. out = min(in + thr, 2^INBITS-1) >> D. The add is INBITS+1 wide
//    and saturates on carry, so it never wraps.
//  - The x phase toggles on every vid_ena cycle and clears on the rising edge of hsync.
//  - The y phase toggles on each hsync rise. It clears on the vsync rise.
//  - frame[1:0] increments on each vsync rise and wraps 3->0.
//  - Ordered mode: idx = {y^frame[0], x^frame[1]}. Bayer LUT {0,2,3,1}[idx] << (D-2).
//  - LFSR mode: 16-bit Fibonacci LFSR, taps 16,14,13,11. It advances only on vid_ena
//    cycles, and thr = lfsr[D-1:0].
//  - Truncate and reserved modes: thr = 0.
//  - A mode change takes effect on the next pixel; there is no glitch guard.
//  - Blanking: when the delayed vid_ena is 0, oRed/oGreen/oBlue are 0, whatever the inputs.
//  - hsync and vsync rising on the same cycle: y clears, frame increments, x clears.
//
// STRUCTURE
//  - Package video_dither_pkg holds:
//    - mode constants: DITHER_TRUNC, DITHER_ORDERED, DITHER_LFSR;
//    - the BAYER2 LUT;
//    - the LFSR tap mask.
//  - Sub-module dither_channel (the add/saturate/truncate path for one channel) is
//    instantiated 3 times and shares thr.
//  - Counters, LFSR and sync delay live in the top module.
//
// TESTING
//  1. mode=0, in=8'hFF/8'h7F/8'h00 -> out 4'hF/4'h7/4'h0, 2 clocks later.
//  2. mode=1, in=8'h08 constant over a 2x2 block, frame 0 -> thr 0,8,12,4 -> outputs
//     0,1,1,0; exactly 2 of every 4 pixels are 1.
//  3. mode=1, in=8'hFE with thr=12 -> out 4'hF; no wrap to 0.
//  4. mode=1, four vsync pulses -> the pattern phase for pixel(0,0) cycles through all
//     4 idx values, then repeats.
//  5. mode=2, in=8'h08 over 4096 vid_ena pixels -> roughly 50% ones; LFSR stalls while
//     vid_ena=0.
//  6. vid_ena=0 with in=8'hFF -> out 0. Assert reset_n low mid-line -> outputs 0 at once,
//     and the counters and LFSR hold their reset values.

Source files
------------

// File: rtl/video_dither_pkg.sv
// Shared definitions for the multi-mode video dither stage.
//   dither_mode_e : run-time dither mode select (values match the mode pin)
//   vid_ctrl_t    : sync/blank bundle carried alongside the data pipeline
//   BAYER2        : 2x2 ordered-dither ranks, indexed by {y, x} phase
//   LFSR_TAPS     : Fibonacci tap mask for x^16 + x^14 + x^13 + x^11 + 1
package video_dither_pkg;

  typedef enum logic [1:0] {
    DITHER_TRUNC   = 2'd0,
    DITHER_ORDERED = 2'd1,
    DITHER_LFSR    = 2'd2,
    DITHER_RSVD    = 2'd3
  } dither_mode_e;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic vid_ena;
  } vid_ctrl_t;

  localparam int unsigned LFSR_W = 16;

  // Bits 15,13,12,10 of the state are the 16,14,13,11 taps.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam logic [1:0] BAYER2 [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

  // One shift of the Fibonacci LFSR; feedback enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/video_dither_multi_channel.sv
// dither_channel: second pipeline stage for one colour channel.
// Adds the threshold with one extra bit of headroom, saturates on carry,
// keeps the top OUTBITS and forces zero outside the active window.
//   clk, reset_n : clock, async active-low reset
//   pix_i        : stage-1 registered pixel value (INBITS)
//   thr_i        : stage-1 registered threshold (INBITS)
//   ena_i        : stage-1 registered vid_ena
//   pix_o        : registered dithered output (OUTBITS)
module dither_channel
  import video_dither_pkg::*;
#(
  parameter int unsigned INBITS  = 8,
  parameter int unsigned OUTBITS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INBITS-1:0]  pix_i,
  input  logic [INBITS-1:0]  thr_i,
  input  logic               ena_i,
  output logic [OUTBITS-1:0] pix_o
);

  localparam int unsigned D = INBITS - OUTBITS;

  logic [INBITS:0]    sum_c;
  logic [INBITS-1:0]  sat_c;
  logic [OUTBITS-1:0] pix_d;
  logic [OUTBITS-1:0] pix_q;

  // Add, clamp to full scale on carry, truncate, blank.
  always_comb begin
    sum_c = {1'b0, pix_i} + {1'b0, thr_i};
    sat_c = sum_c[INBITS] ? '1 : sum_c[INBITS-1:0];
    pix_d = ena_i ? sat_c[INBITS-1:D] : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_q <= '0;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign pix_o = pix_q;

endmodule

// File: rtl/video_dither_multi.sv
// video_dither_multi: reduces INBITS-per-channel RGB to OUTBITS per channel
// with a run-time choice of truncation, frame-rotated 2x2 ordered dither or
// temporal LFSR noise. Two-clock latency on data, syncs and vid_ena.
//   clk, reset_n             : clock, async active-low reset
//   mode                     : 0 truncate, 1 ordered 2x2, 2 LFSR, 3 as 0
//   hsync, vsync, vid_ena    : timing inputs (active high)
//   iRed, iGreen, iBlue      : input pixel (INBITS each)
//   oHsync, oVsync, oVid_ena : timing delayed by two clocks
//   oRed, oGreen, oBlue      : dithered pixel (OUTBITS each), 0 when blanked
// INBITS-OUTBITS must lie in [2, 16]; SEED must be non-zero.
module video_dither_multi
  import video_dither_pkg::*;
#(
  parameter int unsigned       INBITS  = 8,
  parameter int unsigned       OUTBITS = 4,
  parameter logic [LFSR_W-1:0] SEED    = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         mode,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               vid_ena,
  input  logic [INBITS-1:0]  iRed,
  input  logic [INBITS-1:0]  iGreen,
  input  logic [INBITS-1:0]  iBlue,
  output logic               oHsync,
  output logic               oVsync,
  output logic               oVid_ena,
  output logic [OUTBITS-1:0] oRed,
  output logic [OUTBITS-1:0] oGreen,
  output logic [OUTBITS-1:0] oBlue
);

  localparam int unsigned D = INBITS - OUTBITS;

  vid_ctrl_t          ctrl_c;
  vid_ctrl_t          ctrl1_q;
  vid_ctrl_t          ctrl2_q;
  logic               hs_prev_q;
  logic               vs_prev_q;
  logic               hs_rise_c;
  logic               vs_rise_c;
  logic               x_q, x_d;
  logic               y_q, y_d;
  logic [1:0]         frame_q, frame_d;
  logic [1:0]         idx_c;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [INBITS-1:0]  thr_d, thr_q;
  logic [INBITS-1:0]  red1_q, green1_q, blue1_q;

  // Threshold select and pattern-phase / LFSR next state.
  always_comb begin
    ctrl_c    = '{hsync: hsync, vsync: vsync, vid_ena: vid_ena};
    hs_rise_c = hsync & ~hs_prev_q;
    vs_rise_c = vsync & ~vs_prev_q;
    // Frame bits swap the pattern rows/columns so each pixel sees all four ranks.
    idx_c     = {y_q ^ frame_q[0], x_q ^ frame_q[1]};

    thr_d = '0;
    case (dither_mode_e'(mode))
      DITHER_ORDERED: thr_d = INBITS'(BAYER2[idx_c]) << (D - 2);
      DITHER_LFSR:    thr_d = INBITS'(lfsr_q[D-1:0]);
      default:        thr_d = '0;
    endcase

    x_d = x_q;
    if (hs_rise_c) begin
      x_d = 1'b0;
    end else if (vid_ena) begin
      x_d = ~x_q;
    end

    // vsync rise wins over a coincident hsync rise.
    y_d = y_q;
    if (vs_rise_c) begin
      y_d = 1'b0;
    end else if (hs_rise_c) begin
      y_d = ~y_q;
    end

    frame_d = vs_rise_c ? frame_q + 2'd1 : frame_q;

    // Noise only advances on active pixels so blanking does not consume it.
    lfsr_d = vid_ena ? lfsr_step(lfsr_q) : lfsr_q;
  end

  // Stage 1 data/threshold, timing delay line and phase state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl1_q   <= '0;
      ctrl2_q   <= '0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      x_q       <= 1'b0;
      y_q       <= 1'b0;
      frame_q   <= '0;
      lfsr_q    <= SEED;
      thr_q     <= '0;
      red1_q    <= '0;
      green1_q  <= '0;
      blue1_q   <= '0;
    end else begin
      ctrl1_q   <= ctrl_c;
      ctrl2_q   <= ctrl1_q;
      hs_prev_q <= hsync;
      vs_prev_q <= vsync;
      x_q       <= x_d;
      y_q       <= y_d;
      frame_q   <= frame_d;
      lfsr_q    <= lfsr_d;
      thr_q     <= thr_d;
      red1_q    <= iRed;
      green1_q  <= iGreen;
      blue1_q   <= iBlue;
    end
  end

  // Stage 2: one add/saturate/truncate path per channel, sharing the threshold.
  dither_channel #(.INBITS(INBITS), .OUTBITS(OUTBITS)) u_red (
    .clk     (clk),
    .reset_n (reset_n),
    .pix_i   (red1_q),
    .thr_i   (thr_q),
    .ena_i   (ctrl1_q.vid_ena),
    .pix_o   (oRed)
  );

  dither_channel #(.INBITS(INBITS), .OUTBITS(OUTBITS)) u_green (
    .clk     (clk),
    .reset_n (reset_n),
    .pix_i   (green1_q),
    .thr_i   (thr_q),
    .ena_i   (ctrl1_q.vid_ena),
    .pix_o   (oGreen)
  );

  dither_channel #(.INBITS(INBITS), .OUTBITS(OUTBITS)) u_blue (
    .clk     (clk),
    .reset_n (reset_n),
    .pix_i   (blue1_q),
    .thr_i   (thr_q),
    .ena_i   (ctrl1_q.vid_ena),
    .pix_o   (oBlue)
  );

  assign oHsync   = ctrl2_q.hsync;
  assign oVsync   = ctrl2_q.vsync;
  assign oVid_ena = ctrl2_q.vid_ena;

endmodule

// File: tb/tb_video_dither_multi.sv
// Bench for video_dither_multi (INBITS=8, OUTBITS=4): a per-pixel arithmetic
// model with a two-deep delay line is compared every cycle, and directed
// vectors pin individual results by hand-computed constants.
module tb_video_dither_multi;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       hsync = 1'b0, vsync = 1'b0, vid_ena = 1'b0;
  logic [7:0] iRed = '0, iGreen = '0, iBlue = '0;
  logic       oHsync, oVsync, oVid_ena;
  logic [3:0] oRed, oGreen, oBlue;

  int n_assert = 0;
  int n_fail   = 0;

  video_dither_multi #(.INBITS(8), .OUTBITS(4), .SEED(16'hACE1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .mode     (mode),
    .hsync    (hsync),
    .vsync    (vsync),
    .vid_ena  (vid_ena),
    .iRed     (iRed),
    .iGreen   (iGreen),
    .iBlue    (iBlue),
    .oHsync   (oHsync),
    .oVsync   (oVsync),
    .oVid_ena (oVid_ena),
    .oRed     (oRed),
    .oGreen   (oGreen),
    .oBlue    (oBlue)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic       hs, vs, ve;
    logic [3:0] r, g, b;
  } exp_t;

  exp_t        pipe [2];
  int          bayer [4] = '{0, 2, 3, 1};
  int          mx, my, mfr, mthr, midx;
  logic        mhp, mvp, mhr, mvr;
  logic [15:0] ml;

  function automatic logic [3:0] dith(input logic [7:0] v, input int thr);
    int s;
    s = int'(v) + thr;
    if (s > 255) s = 255;
    return 4'(s / 16);
  endfunction

  task automatic model_clear();
    mx = 0; my = 0; mfr = 0; mhp = 1'b0; mvp = 1'b0; ml = 16'hACE1;
    for (int i = 0; i < 2; i++) pipe[i] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
  endtask

  initial begin : model
    exp_t e;
    model_clear();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        model_clear();
      end else begin
        mhr = hsync && !mhp;
        mvr = vsync && !mvp;
        case (mode)
          2'd1: begin
            midx = 2 * ((my ^ mfr) % 2) + ((mx ^ (mfr / 2)) % 2);
            mthr = bayer[midx] * 4;
          end
          2'd2:    mthr = int'(ml[3:0]);
          default: mthr = 0;
        endcase
        e.hs = hsync; e.vs = vsync; e.ve = vid_ena;
        e.r  = vid_ena ? dith(iRed, mthr)   : 4'h0;
        e.g  = vid_ena ? dith(iGreen, mthr) : 4'h0;
        e.b  = vid_ena ? dith(iBlue, mthr)  : 4'h0;
        pipe[1] = pipe[0];
        pipe[0] = e;
        if (mhr) mx = 0; else if (vid_ena) mx = 1 - mx;
        if (mvr) my = 0; else if (mhr) my = 1 - my;
        if (mvr) mfr = (mfr + 1) % 4;
        if (vid_ena) ml = {ml[14:0], ml[15] ^ ml[13] ^ ml[12] ^ ml[10]};
        mhp = hsync;
        mvp = vsync;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    forever begin
      @(negedge clk);
      n_assert++;
      if (oHsync !== pipe[1].hs || oVsync !== pipe[1].vs || oVid_ena !== pipe[1].ve ||
          oRed !== pipe[1].r || oGreen !== pipe[1].g || oBlue !== pipe[1].b) begin
        n_fail++;
        $display("FAIL model t=%0t got hs=%b vs=%b ve=%b r=%h g=%h b=%h want hs=%b vs=%b ve=%b r=%h g=%h b=%h",
                 $time, oHsync, oVsync, oVid_ena, oRed, oGreen, oBlue,
                 pipe[1].hs, pipe[1].vs, pipe[1].ve, pipe[1].r, pipe[1].g, pipe[1].b);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input logic ve, input logic hs, input logic vs,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    vid_ena = ve; hsync = hs; vsync = vs;
    iRed = r; iGreen = g; iBlue = b;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [11:0] frame_exp [5] = '{12'h111, 12'h110, 12'h010, 12'h000, 12'h111};
  int ones, nve;

  initial begin : stim
    // Reset state
    step(); step(); step();
    check("reset_out", 32'({oHsync, oVsync, oVid_ena, oRed, oGreen, oBlue}), 32'h0);
    reset_n = 1'b1;
    step();

    // Truncate
    mode = 2'd0;
    set_px(1'b1, 1'b0, 1'b0, 8'hFF, 8'h7F, 8'h00);
    step(); step();
    check("trunc_FF", 32'(oRed), 32'hF);
    check("trunc_7F", 32'(oGreen), 32'h7);
    check("trunc_00", 32'(oBlue), 32'h0);

    // Sync latency and blanking of full-scale input
    set_px(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    step();
    check("sync_lat1", 32'({oHsync, oVsync}), 32'h0);
    step();
    check("sync_lat2_blank", 32'({oHsync, oVsync, oVid_ena, oRed, oGreen, oBlue}), 32'h6000);

    // Reset mid-line clears outputs immediately
    set_px(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    step(); step();
    check("pre_reset", 32'(oRed), 32'hF);
    #2 reset_n = 1'b0;
    #1 check("reset_midline", 32'({oVid_ena, oRed, oGreen, oBlue}), 32'h0);
    step();
    set_px(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    step();
    reset_n = 1'b1;

    // LFSR from SEED 0xACE1 (thr 1), holds over blank, then 0x59C3 (thr 3)
    mode = 2'd2;
    set_px(1'b1, 1'b0, 1'b0, 8'h0F, 8'h0E, 8'h00);
    step();
    set_px(1'b0, 1'b0, 1'b0, 8'h0F, 8'h0E, 8'h00);
    step();
    check("lfsr_seed", 32'({oRed, oGreen}), 32'h10);
    set_px(1'b1, 1'b0, 1'b0, 8'h0D, 8'h0C, 8'h00);
    step();
    set_px(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    step();
    check("lfsr_stall", 32'({oRed, oGreen}), 32'h10);

    // Ordered 2x2 block, frame 0, in=0x08
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    mode = 2'd1;
    set_px(1'b1, 1'b0, 1'b0, 8'h08, 8'h08, 8'h08);
    step();
    step();
    check("bayer_x0y0", 32'(oRed), 32'h0);
    set_px(1'b0, 1'b1, 1'b0, 8'h08, 8'h08, 8'h08);
    step();
    check("bayer_x1y0", 32'(oRed), 32'h1);
    set_px(1'b1, 1'b0, 1'b0, 8'h08, 8'h08, 8'h08);
    step();
    check("bayer_hblank", 32'({oVid_ena, oRed}), 32'h0);
    step();
    check("bayer_x0y1", 32'(oRed), 32'h1);
    set_px(1'b0, 1'b0, 1'b0, 8'h08, 8'h08, 8'h08);
    step();
    check("bayer_x1y1", 32'(oRed), 32'h0);

    // Saturation: thr 12 at (0,1) with 0xFE
    set_px(1'b1, 1'b0, 1'b0, 8'hFE, 8'hFE, 8'hFE);
    step();
    set_px(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    step();
    check("sat_FE", 32'({oRed, oGreen, oBlue}), 32'hFFF);

    // Frame rotation for pixel (0,0): thr 12, 8, 4, 0, 12
    for (int k = 0; k < 5; k++) begin
      set_px(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
      step();
      set_px(1'b1, 1'b0, 1'b0, 8'h08, 8'h0C, 8'h04);
      step();
      set_px(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      step();
      check($sformatf("frame_phase%0d", k), 32'({oRed, oGreen, oBlue}), 32'(frame_exp[k]));
    end

    // LFSR noise density over 4096 active pixels with periodic blanking
    mode = 2'd2;
    ones = 0;
    nve = 0;
    for (int i = 0; i < 4096; i++) begin
      set_px(1'b1, 1'b0, 1'b0, 8'h08, 8'h08, 8'h08);
      step();
      if (oVid_ena) begin nve++; if (oRed == 4'h1) ones++; end
      if (i % 64 == 63) begin
        set_px(1'b0, 1'b0, 1'b0, 8'h08, 8'h08, 8'h08);
        step();
        if (oVid_ena) begin nve++; if (oRed == 4'h1) ones++; end
      end
    end
    set_px(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      if (oVid_ena) begin nve++; if (oRed == 4'h1) ones++; end
    end
    check("lfsr_pixels", 32'(nve), 32'd4096);
    check("lfsr_balance", 32'((ones >= 1850) && (ones <= 2250)), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
